sd_spi_engine: RTL and testbench
================================

Name: sd_spi_engine

Overview:
- Hardware SPI master for the two SD card slots; replaces CPU bit-banging of SCLK/MOSI with a byte-wide shift engine.
- Sits in the CPLD I/O area and is clocked from MHZ48.
- The CPU writes a byte and the engine shifts it out in SPI mode 0 while shifting a byte in. The CPU polls BUSY, then reads the received byte.
- Also owns the card-select lines nSD0/nSD1 and a programmable SCLK divider.

Parameters:
- DIV_RESET, 8'd59: divider value after reset. Half-period is (DIV_RESET+1) MHZ48 cycles, so 59 gives 400 kHz for card init.
- IDLE_MOSI, 1'b1: MOSI level when idle.

Ports:
- MHZ48  input  1  master clock; all logic is on the rising edge.
- nRES  input  1  reset, synchronous, active-low.
- WSTB  input  1  one-cycle register write strobe, already synchronised to MHZ48.
- RSTB  input  1  one-cycle register read strobe, already synchronised to MHZ48.
- ADR  input  2  register select: 0 DATA, 1 CTRL, 2 DIV, 3 STATUS.
- DIN  input  8  write data.
- DOUT  output  8  read data for the register selected by ADR; combinational from registers.
- BUSY  output  1  high while a transfer is in progress.
- nSD0  output  1  card 0 select, active-low.
- nSD1  output  1  card 1 select, active-low.
- SCLK  output  1  SPI clock; idles low.
- MOSI  output  1  SPI data out.
- MISO  input  1  SPI data in; sampled on the SCLK rising edge.

Behaviour:
- Reset (nRES low at a clock edge):
  - SCLK=0, MOSI=IDLE_MOSI, nSD0=nSD1=1, BUSY=0.
  - rx=8'hFF, div=DIV_RESET, ovr=0, state=IDLE.
  - Reset mid-transfer aborts immediately; no partial byte is kept.
- Registers:
  - DATA write: loads tx and starts a transfer. DATA read: returns rx.
  - CTRL: bit0 = nSD0 level, bit1 = nSD1 level. Reads return {6'b0,nSD1,nSD0}. Writes take effect next cycle, even while BUSY.
  - DIV: 8-bit divider, read/write. Writes while BUSY are ignored.
  - STATUS: read returns {ovr,6'b0,BUSY}. Any STATUS read clears ovr.
- State machine (IDLE, LOW, HIGH):
  - IDLE, WSTB to DATA:
    - sr<=DIN, MOSI<=DIN[7], bit counter<=7, half-period counter<=div.
    - Go to LOW; BUSY=1 from the next cycle.
  - LOW: SCLK=0. When the half counter reaches 0:
    - SCLK<=1 and sample MISO into sr LSB after shifting left.
    - Reload the counter and go to HIGH.
  - HIGH: SCLK=1. When the counter reaches 0:
    - SCLK<=0.
    - If bit counter=0: rx<=sr, MOSI<=IDLE_MOSI, go to IDLE with BUSY=0 in the same edge.
    - Else: decrement the bit counter, MOSI<=sr[7] (next bit), reload the counter, go to LOW.
- Byte timing:
  - Full byte is 16*(div+1) MHZ48 cycles from the cycle after WSTB to the cycle BUSY falls.
  - div=0 gives 24 MHz SCLK, the maximum.
- DATA write while BUSY: ignored, tx unchanged, ovr<=1.
- WSTB and RSTB asserted together: the write is performed; DOUT shows the pre-write register value.
- A DATA read during BUSY returns the previous rx. rx updates only at byte end.
- Back-to-back: a DATA write in the same cycle BUSY falls is treated as busy (ovr=1). The first accepted write is the cycle after BUSY=0.

Optional Feature:
- Macro SD_SPI_AUTOREAD_EN.
- Defined:
  - A DATA read with BUSY=0 returns rx and also starts a transfer with tx=8'hFF, exactly as if 8'hFF had been written.
  - A DATA read while BUSY returns rx, starts nothing and does not set ovr.
  - Enables streaming sector reads with one bus access per byte.
- Not defined: DATA reads have no side effects.

Test Plan:
- Reset: nRES=0 for 2 cycles → SCLK=0, MOSI=1, nSD0=nSD1=1, BUSY=0, DIV reads 59, DATA reads FF, STATUS reads 00.
- div=0, write DATA=8'hA5, MISO driven with 8'h3C MSB-first → MOSI shows 1,0,1,0,0,1,0,1. Exactly 8 SCLK rising edges; BUSY high for 16 cycles. DATA reads 3C.
- Reset div (59), write DATA=8'h00 → each SCLK half-period is 60 cycles, BUSY high for 960 cycles, SCLK ends low.
- During a transfer: write DATA=8'h11 → ovr set and transmitted byte unchanged. STATUS read returns 81 then 01. A second STATUS read after BUSY falls returns 00.
- Write CTRL=8'h02 mid-transfer → nSD0=0, nSD1=1 on the next cycle; transfer completes unaffected. Write DIV=5 while BUSY → DIV still reads old value.
- nRES pulsed at bit 3 of a transfer → BUSY=0 and SCLK=0 at the next edge, DATA reads FF. With SD_SPI_AUTOREAD_EN, a DATA read afterwards starts a transfer with MOSI=1 for all 8 bits.

Source files
------------

// File: rtl/sd_spi_engine_if.sv
// Bus and SPI pin bundle for sd_spi_engine.
// slave  : the engine itself (CPU register port in, SPI pins out, MISO in).
// master : the host side, i.e. CPU bus plus the card driving MISO.
interface sd_spi_engine_if;
    logic       WSTB;
    logic       RSTB;
    logic [1:0] ADR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       BUSY;
    logic       nSD0;
    logic       nSD1;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;

    modport slave (
        input  WSTB, RSTB, ADR, DIN, MISO,
        output DOUT, BUSY, nSD0, nSD1, SCLK, MOSI
    );

    modport master (
        output WSTB, RSTB, ADR, DIN, MISO,
        input  DOUT, BUSY, nSD0, nSD1, SCLK, MOSI
    );
endinterface

// File: rtl/sd_spi_engine.sv
// sd_spi_engine: byte-wide SPI mode-0 master for the two SD card slots.
// CPU registers: 0 DATA, 1 CTRL (card selects), 2 DIV (SCLK divider), 3 STATUS.
// One SCLK half-period lasts (div+1) MHZ48 cycles; a byte takes 16*(div+1).
// Optional build macro SD_SPI_AUTOREAD_EN: an idle DATA read also launches
// an 8'hFF transfer so sector reads need one bus access per byte.
module sd_spi_engine #(
    parameter logic [7:0] DIV_RESET = 8'd59,
    parameter logic       IDLE_MOSI = 1'b1
) (
    input  logic           MHZ48,
    input  logic           nRES,
    sd_spi_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_CTRL   = 2'd1;
    localparam logic [1:0] ADR_DIV    = 2'd2;
    localparam logic [1:0] ADR_STATUS = 2'd3;

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] div_q, div_d;
    logic [7:0] half_q, half_d;
    logic [2:0] bit_q, bit_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       nsd0_q, nsd0_d;
    logic       nsd1_q, nsd1_d;
    logic       busy_q, busy_d;
    logic       ovr_q, ovr_d;

    logic       wr_data;
    logic       wr_ctrl;
    logic       wr_div;
    logic       rd_status;
    logic       auto_rd;
    logic [7:0] start_byte;
    logic [7:0] dout;

    // Decode the one-cycle bus strobes into register actions.
    always_comb begin
        wr_data   = bus.WSTB && (bus.ADR == ADR_DATA);
        wr_ctrl   = bus.WSTB && (bus.ADR == ADR_CTRL);
        wr_div    = bus.WSTB && (bus.ADR == ADR_DIV);
        rd_status = bus.RSTB && (bus.ADR == ADR_STATUS);
    end

`ifdef SD_SPI_AUTOREAD_EN
    // A DATA read doubles as a "send FF" request; a simultaneous write wins.
    assign auto_rd = bus.RSTB && (bus.ADR == ADR_DATA) && !wr_data;
`else
    assign auto_rd = 1'b0;
`endif

    // Byte loaded into the shifter when a transfer launches.
    assign start_byte = wr_data ? bus.DIN : 8'hFF;

    // Next-state logic for the transfer FSM and the CPU-visible registers.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rx_d    = rx_q;
        div_d   = div_q;
        half_d  = half_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        nsd0_d  = nsd0_q;
        nsd1_d  = nsd1_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;

        // Card selects follow CTRL writes at any time, including mid-byte.
        if (wr_ctrl) begin
            nsd0_d = bus.DIN[0];
            nsd1_d = bus.DIN[1];
        end

        // Reading STATUS clears the overrun flag; a same-cycle overrun below
        // overrides the clear so the event is never lost.
        if (rd_status) begin
            ovr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (wr_div) begin
                    div_d = bus.DIN;
                end
                if (wr_data || auto_rd) begin
                    sr_d    = start_byte;
                    mosi_d  = start_byte[7];
                    bit_d   = 3'd7;
                    half_d  = div_q;
                    busy_d  = 1'b1;
                    state_d = LOW;
                end
            end

            LOW: begin
                if (wr_data) begin
                    ovr_d = 1'b1;
                end
                if (half_q == 8'd0) begin
                    // Rising SCLK: capture MISO into the freed LSB.
                    sclk_d  = 1'b1;
                    sr_d    = {sr_q[6:0], bus.MISO};
                    half_d  = div_q;
                    state_d = HIGH;
                end else begin
                    half_d = half_q - 8'd1;
                end
            end

            HIGH: begin
                if (wr_data) begin
                    ovr_d = 1'b1;
                end
                if (half_q == 8'd0) begin
                    sclk_d = 1'b0;
                    if (bit_q == 3'd0) begin
                        rx_d    = sr_q;
                        mosi_d  = IDLE_MOSI;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // Falling SCLK: present the next bit, now at sr[7].
                        bit_d   = bit_q - 3'd1;
                        mosi_d  = sr_q[7];
                        half_d  = div_q;
                        state_d = LOW;
                    end
                end else begin
                    half_d = half_q - 8'd1;
                end
            end

            default: begin
                sclk_d  = 1'b0;
                mosi_d  = IDLE_MOSI;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control and status flops; reset aborts any transfer in flight.
    always_ff @(posedge MHZ48) begin
        if (!nRES) begin
            state_q <= IDLE;
            rx_q    <= 8'hFF;
            div_q   <= DIV_RESET;
            half_q  <= 8'd0;
            bit_q   <= 3'd0;
            sclk_q  <= 1'b0;
            mosi_q  <= IDLE_MOSI;
            nsd0_q  <= 1'b1;
            nsd1_q  <= 1'b1;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            div_q   <= div_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            nsd0_q  <= nsd0_d;
            nsd1_q  <= nsd1_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    // Shift register is pure data; it is always reloaded before use.
    always_ff @(posedge MHZ48) begin
        sr_q <= sr_d;
    end

    // Read mux; combinational from registers so it shows pre-write values.
    always_comb begin
        dout = 8'h00;
        case (bus.ADR)
            ADR_DATA:   dout = rx_q;
            ADR_CTRL:   dout = {6'b0, nsd1_q, nsd0_q};
            ADR_DIV:    dout = div_q;
            ADR_STATUS: dout = {ovr_q, 6'b0, busy_q};
            default:    dout = 8'h00;
        endcase
    end

    assign bus.DOUT = dout;
    assign bus.BUSY = busy_q;
    assign bus.nSD0 = nsd0_q;
    assign bus.nSD1 = nsd1_q;
    assign bus.SCLK = sclk_q;
    assign bus.MOSI = mosi_q;

endmodule

// File: tb/tb_sd_spi_engine.sv
// Testbench for sd_spi_engine: register vectors, transfer vectors and
// hand-written multi-cycle sequences (overrun, back-to-back, reset abort).
module tb_sd_spi_engine;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_CTRL = 2'd1;
    localparam logic [1:0] A_DIV  = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;
    localparam int         LIMIT  = 5000;

    logic clk  = 1'b0;
    logic nres = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    sd_spi_engine_if bus ();

    sd_spi_engine #(
        .DIV_RESET (8'd59),
        .IDLE_MOSI (1'b1)
    ) dut (
        .MHZ48 (clk),
        .nRES  (nres),
        .bus   (bus)
    );

    // Card model: counts SCLK rises, records MOSI, serves miso_pat MSB-first.
    int unsigned rise_total = 0;
    int unsigned rise_base  = 0;
    logic [7:0]  miso_pat   = 8'hFF;
    logic [7:0]  mosi_cap   = 8'h00;
    int unsigned miso_idx;
    logic [2:0]  miso_sel;

    always @(posedge bus.SCLK) begin
        rise_total <= rise_total + 1;
        mosi_cap   <= {mosi_cap[6:0], bus.MOSI};
    end

    always_comb begin
        miso_idx = rise_total - rise_base;
        miso_sel = 3'd7 - miso_idx[2:0];
        bus.MISO = (miso_idx < 8) ? miso_pat[miso_sel] : 1'b1;
    end

    typedef struct {
        logic       wr;
        logic [1:0] adr;
        logic [7:0] din;
        logic [7:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [7:0] div;
        logic [7:0] tx;
        logic [7:0] pat;
        logic [7:0] exp_rx;
        int         exp_busy;
        int         exp_hi;
        int         exp_lo;
    } xfer_vec_t;

    reg_vec_t  rv[11];
    xfer_vec_t xv[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] adr, input logic [7:0] din);
        @(negedge clk);
        bus.ADR  = adr;
        bus.DIN  = din;
        bus.WSTB = 1'b1;
        @(negedge clk);
        bus.WSTB = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] adr, output logic [7:0] data);
        @(negedge clk);
        bus.ADR  = adr;
        bus.RSTB = 1'b1;
        #2;
        data = bus.DOUT;
        @(negedge clk);
        bus.RSTB = 1'b0;
    endtask

    task automatic bus_rw(input logic [1:0] adr, input logic [7:0] din, output logic [7:0] data);
        @(negedge clk);
        bus.ADR  = adr;
        bus.DIN  = din;
        bus.WSTB = 1'b1;
        bus.RSTB = 1'b1;
        #2;
        data = bus.DOUT;
        @(negedge clk);
        bus.WSTB = 1'b0;
        bus.RSTB = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.BUSY !== 1'b0 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=busy required=idle", tag);
        end
    endtask

    // Register read that lets an autoread-launched byte finish first.
    task automatic rd_reg(input logic [1:0] adr, output logic [7:0] data);
        bus_read(adr, data);
`ifdef SD_SPI_AUTOREAD_EN
        if (adr == A_DATA) begin
            @(negedge clk);
            wait_idle("autoread_settle");
        end
`endif
    endtask

    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] pat,
                            output int busy_cnt, output int hi_cnt, output int lo_first);
        miso_pat  = pat;
        rise_base = rise_total;
        bus_write(A_DATA, tx);
        busy_cnt = 0;
        hi_cnt   = 0;
        lo_first = 0;
        while (bus.BUSY === 1'b1 && busy_cnt < LIMIT) begin
            busy_cnt++;
            if (bus.SCLK === 1'b1) hi_cnt++;
            else if (rise_total == rise_base) lo_first++;
            @(negedge clk);
        end
        if (busy_cnt >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout actual=busy required=idle");
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         bc, hc, lc, n;

        rv[0]  = '{1'b0, A_CTRL, 8'h00, 8'h03};
        rv[1]  = '{1'b0, A_DIV,  8'h00, 8'h3B};
        rv[2]  = '{1'b0, A_STAT, 8'h00, 8'h00};
        rv[3]  = '{1'b0, A_DATA, 8'h00, 8'hFF};
        rv[4]  = '{1'b1, A_CTRL, 8'h01, 8'h01};
        rv[5]  = '{1'b1, A_CTRL, 8'hFE, 8'h02};
        rv[6]  = '{1'b1, A_DIV,  8'h00, 8'h00};
        rv[7]  = '{1'b1, A_DIV,  8'hA7, 8'hA7};
        rv[8]  = '{1'b1, A_CTRL, 8'h03, 8'h03};
        rv[9]  = '{1'b1, A_STAT, 8'hFF, 8'h00};
        rv[10] = '{1'b1, A_DIV,  8'h3B, 8'h3B};

        xv[0] = '{8'd0,  8'hA5, 8'h3C, 8'h3C, 16,  8,   1};
        xv[1] = '{8'd2,  8'h5A, 8'hC3, 8'hC3, 48,  24,  3};
        xv[2] = '{8'd0,  8'hFF, 8'h00, 8'h00, 16,  8,   1};
        xv[3] = '{8'd59, 8'h00, 8'h81, 8'h81, 960, 480, 60};

        bus.WSTB = 1'b0;
        bus.RSTB = 1'b0;
        bus.ADR  = 2'd0;
        bus.DIN  = 8'h00;

        nres = 1'b0;
        repeat (2) @(negedge clk);
        nres = 1'b1;

        chk("rst_sclk", bus.SCLK, 1'b0);
        chk("rst_mosi", bus.MOSI, 1'b1);
        chk("rst_nsd0", bus.nSD0, 1'b1);
        chk("rst_nsd1", bus.nSD1, 1'b1);
        chk("rst_busy", bus.BUSY, 1'b0);

        for (int i = 0; i < 11; i++) begin
            if (rv[i].wr) bus_write(rv[i].adr, rv[i].din);
            rd_reg(rv[i].adr, rd);
            chk($sformatf("reg_vec%0d", i), rd, rv[i].exp);
        end

        for (int i = 0; i < 4; i++) begin
            bus_write(A_DIV, xv[i].div);
            run_xfer(xv[i].tx, xv[i].pat, bc, hc, lc);
            chk($sformatf("xfer%0d_busy_cycles", i), bc, xv[i].exp_busy);
            chk($sformatf("xfer%0d_sclk_high", i), hc, xv[i].exp_hi);
            chk($sformatf("xfer%0d_first_low", i), lc, xv[i].exp_lo);
            chk($sformatf("xfer%0d_rises", i), rise_total - rise_base, 8);
            chk($sformatf("xfer%0d_mosi", i), mosi_cap, xv[i].tx);
            chk($sformatf("xfer%0d_sclk_end", i), bus.SCLK, 1'b0);
            chk($sformatf("xfer%0d_mosi_end", i), bus.MOSI, 1'b1);
            rd_reg(A_DATA, rd);
            chk($sformatf("xfer%0d_rx", i), rd, xv[i].exp_rx);
        end

        // Simultaneous write and read: DOUT shows the old value.
        bus_rw(A_DIV, 8'h03, rd);
        chk("rw_old_div", rd, 8'h3B);
        bus_read(A_DIV, rd);
        chk("rw_new_div", rd, 8'h03);

        // Overrun, CTRL and DIV writes during a transfer.
        miso_pat  = 8'h96;
        rise_base = rise_total;
        bus_write(A_DATA, 8'hC3);
        repeat (10) @(negedge clk);
        bus_write(A_DATA, 8'h11);
        bus_read(A_STAT, rd);
        chk("ovr_status1", rd, 8'h81);
        bus_read(A_STAT, rd);
        chk("ovr_status2", rd, 8'h01);
        bus_write(A_CTRL, 8'h02);
        chk("ctrl_nsd0", bus.nSD0, 1'b0);
        chk("ctrl_nsd1", bus.nSD1, 1'b1);
        bus_write(A_DIV, 8'h05);
        bus_read(A_DIV, rd);
        chk("div_busy_ignored", rd, 8'h03);
        wait_idle("ovr_xfer");
        chk("ovr_rises", rise_total - rise_base, 8);
        chk("ovr_mosi_unchanged", mosi_cap, 8'hC3);
        bus_read(A_STAT, rd);
        chk("ovr_status_after", rd, 8'h00);
        rd_reg(A_DATA, rd);
        chk("ovr_rx", rd, 8'h96);
        bus_write(A_CTRL, 8'h03);

        // Back-to-back: a write on the edge BUSY falls counts as overrun.
        bus_write(A_DIV, 8'h00);
        miso_pat  = 8'hFF;
        rise_base = rise_total;
        bus_write(A_DATA, 8'h12);
        repeat (14) @(negedge clk);
        bus_write(A_DATA, 8'h34);
        chk("b2b_busy_fell", bus.BUSY, 1'b0);
        chk("b2b_first_mosi", mosi_cap, 8'h12);
        bus_read(A_STAT, rd);
        chk("b2b_ovr", rd, 8'h80);
        rise_base = rise_total;
        bus_write(A_DATA, 8'h34);
        chk("b2b_accept_busy", bus.BUSY, 1'b1);
        wait_idle("b2b_xfer");
        chk("b2b_second_mosi", mosi_cap, 8'h34);
        bus_read(A_STAT, rd);
        chk("b2b_status_end", rd, 8'h00);

        // Reset in the middle of a byte.
        bus_write(A_DIV, 8'h03);
        bus_write(A_CTRL, 8'h00);
        miso_pat  = 8'h00;
        rise_base = rise_total;
        bus_write(A_DATA, 8'h0F);
        n = 0;
        while ((rise_total - rise_base) < 4 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        chk("mid_reached_bit3", (rise_total - rise_base) >= 4, 1'b1);
        nres = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", bus.BUSY, 1'b0);
        chk("mid_rst_sclk", bus.SCLK, 1'b0);
        chk("mid_rst_mosi", bus.MOSI, 1'b1);
        chk("mid_rst_nsd0", bus.nSD0, 1'b1);
        nres = 1'b1;
        bus_read(A_DIV, rd);
        chk("mid_rst_div", rd, 8'h3B);
        miso_pat  = 8'h55;
        rise_base = rise_total;
        bus_read(A_DATA, rd);
        chk("mid_rst_rx", rd, 8'hFF);
`ifdef SD_SPI_AUTOREAD_EN
        chk("auto_busy", bus.BUSY, 1'b1);
        wait_idle("auto_xfer");
        chk("auto_rises", rise_total - rise_base, 8);
        chk("auto_mosi_ff", mosi_cap, 8'hFF);
        bus_read(A_STAT, rd);
        chk("auto_no_ovr", rd, 8'h00);
        bus_read(A_DATA, rd);
        chk("auto_rx", rd, 8'h55);
        wait_idle("auto_xfer2");
`else
        repeat (3) @(negedge clk);
        chk("noauto_busy", bus.BUSY, 1'b0);
        chk("noauto_rises", rise_total - rise_base, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
